ir_fetch_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 16-bit processor. It drives the memory read strobe, the instruction register load enable, the PC increment and the execute enable. It reads the opcode back from the instruction register output, decides execute length, and detects halt and memory-timeout faults. It sits between program memory, the PC, the instruction register and the datapath.

---
 rtl/ir_fetch_ctrl_if.sv | 36 +++
 rtl/ir_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_ir_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_fetch_ctrl_if.sv
// Handshake bundle between the fetch sequencer and memory, IR and datapath.
// Optional step-mode pins are present only when IR_FETCH_STEP_EN is defined.
interface ir_fetch_ctrl_if;
  logic       run;
  logic       mem_ready;
  logic [3:0] opcode;
  logic       mem_rd;
  logic       ir_load;
  logic       pc_inc;
  logic       exec_en;
  logic       halted;
  logic       fault;
  logic [2:0] state;
`ifdef IR_FETCH_STEP_EN
  logic       step_mode;
  logic       step;

  modport master (
    input  run, mem_ready, opcode, step_mode, step,
    output mem_rd, ir_load, pc_inc, exec_en, halted, fault, state
  );
  modport slave (
    output run, mem_ready, opcode, step_mode, step,
    input  mem_rd, ir_load, pc_inc, exec_en, halted, fault, state
  );
`else
  modport master (
    input  run, mem_ready, opcode,
    output mem_rd, ir_load, pc_inc, exec_en, halted, fault, state
  );
  modport slave (
    output run, mem_ready, opcode,
    input  mem_rd, ir_load, pc_inc, exec_en, halted, fault, state
  );
`endif
endinterface

// File: rtl/ir_fetch_ctrl.sv
// Fetch/wait/load/decode/execute sequencer with halt and memory-timeout detection.
// Optional single-step control is enabled by defining IR_FETCH_STEP_EN.
module ir_fetch_ctrl #(
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter logic [3:0]  MULTI_LO  = 4'hC,
  parameter int unsigned MULTI_LEN = 3,
  parameter int unsigned TIMEOUT   = 8
) (
  input logic            clk,
  input logic            reset,
  ir_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_LOAD   = 3'd3,
    S_DECODE = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [2:0] MULTI_LEN_C  = 3'(MULTI_LEN);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e     state_r, state_next;
  logic [2:0] cnt_r, cnt_next;
  logic [7:0] timer_r, timer_next;
  logic       start_req;
  state_e     after_exec;

  logic mem_rd_r, ir_load_r, pc_inc_r, exec_en_r, halted_r, fault_r;
  logic mem_rd_next, ir_load_next, pc_inc_next, exec_en_next, halted_next, fault_next;

`ifdef IR_FETCH_STEP_EN
  // In step mode a single step pulse launches exactly one instruction, then we park in IDLE.
  assign start_req  = bus.step_mode ? bus.step : bus.run;
  assign after_exec = (bus.step_mode || !bus.run) ? S_IDLE : S_FETCH;
`else
  assign start_req  = bus.run;
  assign after_exec = bus.run ? S_FETCH : S_IDLE;
`endif

  // Next-state, execute counter and wait-timer logic.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    timer_next = timer_r;
    case (state_r)
      S_IDLE: begin
        if (start_req) state_next = S_FETCH;
        else           state_next = S_IDLE;
      end
      S_FETCH: begin
        timer_next = 8'd0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Ready takes priority over a timeout expiring on the same edge.
        if (bus.mem_ready) begin
          state_next = S_LOAD;
        end else begin
          timer_next = timer_r + 8'd1;
          if (timer_r == TIMEOUT_LAST) state_next = S_FAULT;
          else                         state_next = S_WAIT;
        end
      end
      S_LOAD: state_next = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == HALT_OP) begin
          state_next = S_HALT;
        end else if (bus.opcode >= MULTI_LO && bus.opcode < HALT_OP) begin
          cnt_next   = MULTI_LEN_C;
          state_next = S_EXEC;
        end else begin
          cnt_next   = 3'd1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_next = cnt_r - 3'd1;
        if (cnt_r == 3'd1) state_next = after_exec;
        else               state_next = S_EXEC;
      end
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies track the state register exactly.
  always_comb begin
    mem_rd_next  = (state_next == S_FETCH) || (state_next == S_WAIT);
    ir_load_next = (state_next == S_LOAD);
    pc_inc_next  = (state_next == S_LOAD);
    exec_en_next = (state_next == S_EXEC);
    halted_next  = (state_next == S_HALT);
    fault_next   = (state_next == S_FAULT);
  end

  // State, counters and output registers; reset aborts any cycle in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= 3'd0;
      timer_r   <= 8'd0;
      mem_rd_r  <= 1'b0;
      ir_load_r <= 1'b0;
      pc_inc_r  <= 1'b0;
      exec_en_r <= 1'b0;
      halted_r  <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_next;
      cnt_r     <= cnt_next;
      timer_r   <= timer_next;
      mem_rd_r  <= mem_rd_next;
      ir_load_r <= ir_load_next;
      pc_inc_r  <= pc_inc_next;
      exec_en_r <= exec_en_next;
      halted_r  <= halted_next;
      fault_r   <= fault_next;
    end
  end

  assign bus.state   = state_r;
  assign bus.mem_rd  = mem_rd_r;
  assign bus.ir_load = ir_load_r;
  assign bus.pc_inc  = pc_inc_r;
  assign bus.exec_en = exec_en_r;
  assign bus.halted  = halted_r;
  assign bus.fault   = fault_r;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed bench for ir_fetch_ctrl: models a tiny IR and checks state/output sequences.
module tb_ir_fetch_ctrl;
  logic clk;
  logic reset;
  logic [15:0] ins;
  logic [15:0] ir;
  int ir_loads;
  int pc_incs;
  int checks;
  int failures;

  ir_fetch_ctrl_if bus ();

  ir_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction register and load/increment event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= 16'h0000;
    end else if (bus.ir_load) begin
      ir <= ins;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.ir_load) ir_loads <= ir_loads + 1;
    if (bus.pc_inc)  pc_incs  <= pc_incs + 1;
  end
  assign bus.opcode = ir[15:12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Walks expected states one cycle at a time and checks Moore outputs against each.
  task automatic expect_seq(input string name, input logic [2:0] seq[], input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (bus.state !== seq[i]) begin
        failures++;
        $display("FAIL %s[%0d] state got=%0d want=%0d", name, i, bus.state, seq[i]);
      end
      checks++;
      if ({bus.mem_rd, bus.ir_load, bus.pc_inc, bus.exec_en} !==
          {(seq[i] == 3'd1 || seq[i] == 3'd2), seq[i] == 3'd3, seq[i] == 3'd3, seq[i] == 3'd5}) begin
        failures++;
        $display("FAIL %s[%0d] outs got=%b%b%b%b state_want=%0d", name, i,
                 bus.mem_rd, bus.ir_load, bus.pc_inc, bus.exec_en, seq[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    ins = 16'h0000;
    ir_loads = 0;
    pc_incs = 0;
    #2;
    checks++;
    if ({bus.state, bus.mem_rd, bus.ir_load, bus.pc_inc, bus.exec_en, bus.halted, bus.fault} !== 9'd0) begin
      failures++;
      $display("FAIL reset_state got state=%0d outs=%b%b%b%b%b%b want all 0", bus.state,
               bus.mem_rd, bus.ir_load, bus.pc_inc, bus.exec_en, bus.halted, bus.fault);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.state !== 3'd0) begin
      failures++;
      $display("FAIL idle_no_run got=%0d want=0", bus.state);
    end
  endtask

  task automatic test_single_cycle();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    int l0, p0;
    do_reset();
    ins = 16'h1234;
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    l0 = ir_loads;
    p0 = pc_incs;
    expect_seq("single", seq, 11);
    checks++;
    if (ir_loads - l0 !== 2 || pc_incs - p0 !== 2) begin
      failures++;
      $display("FAIL single_loads got ir_load=%0d pc_inc=%0d want 2/2", ir_loads - l0, pc_incs - p0);
    end
    checks++;
    if (ir !== 16'h1234) begin
      failures++;
      $display("FAIL single_ir got=%h want=1234", ir);
    end
  endtask

  task automatic test_multi_cycle();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd1};
    do_reset();
    ins = 16'hD00D;
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    expect_seq("multi_D", seq, 8);
  endtask

  task automatic test_timeout();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd7};
    do_reset();
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    expect_seq("timeout", seq, 10);
    for (int i = 0; i < 4; i++) begin
      bus.run = i[0];
      bus.mem_ready = ~i[0];
      tick();
      checks++;
      if (bus.state !== 3'd7 || bus.fault !== 1'b1 || bus.mem_rd !== 1'b0) begin
        failures++;
        $display("FAIL fault_sticky[%0d] got state=%0d fault=%b mem_rd=%b want 7/1/0",
                 i, bus.state, bus.fault, bus.mem_rd);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    do_reset();
    ins = 16'h2000;
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    expect_seq("tmo_edge", seq, 9);
    bus.mem_ready = 1'b1;
    tick();
    checks++;
    if (bus.state !== 3'd3 || bus.fault !== 1'b0) begin
      failures++;
      $display("FAIL ready_wins got state=%0d fault=%b want 3/0", bus.state, bus.fault);
    end
  endtask

  task automatic test_halt();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    do_reset();
    ins = 16'hF000;
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    expect_seq("halt", seq, 5);
    for (int i = 0; i < 4; i++) begin
      bus.run = i[0];
      tick();
      checks++;
      if (bus.state !== 3'd6 || bus.halted !== 1'b1 || bus.exec_en !== 1'b0) begin
        failures++;
        $display("FAIL halt_sticky[%0d] got state=%0d halted=%b want 6/1", i, bus.state, bus.halted);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset got state=%0d halted=%b want 0/0", bus.state, bus.halted);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    logic [2:0] tail[] = '{3'd5, 3'd0, 3'd0};
    do_reset();
    ins = 16'hC000;
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    expect_seq("drop_head", seq, 6);
    bus.run = 1'b0;
    expect_seq("drop_tail", tail, 3);
  endtask

  task automatic test_reset_in_wait();
    logic [2:0] seq[] = '{3'd1, 3'd2, 3'd2};
    int l0;
    logic [15:0] ir0;
    do_reset();
    ins = 16'h5A5A;
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    expect_seq("rst_wait", seq, 3);
    l0 = ir_loads;
    ir0 = ir;
    bus.mem_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.mem_rd !== 1'b0 || bus.ir_load !== 1'b0 || bus.pc_inc !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got state=%0d mem_rd=%b ir_load=%b pc_inc=%b want 0", bus.state,
               bus.mem_rd, bus.ir_load, bus.pc_inc);
    end
    bus.run = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ir_loads !== l0 || ir !== ir0 || bus.state !== 3'd0) begin
      failures++;
      $display("FAIL no_partial_load got loads=%0d ir=%h state=%0d want loads=%0d ir=%h state=0",
               ir_loads, ir, bus.state, l0, ir0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
`ifdef IR_FETCH_STEP_EN
    bus.step_mode = 1'b0;
    bus.step = 1'b0;
`endif
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_timeout();
    test_timeout_boundary();
    test_halt();
    test_run_drop();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
